// File: rtl/speed_limit_arbiter.sv
// Fixed-priority (drv > sign > map) speed-limit select with hold window and stale fallback; 1-cycle registered outputs.
// Un-acked requests simply stay pending at the requester. `SPEED_LIMIT_RAMP_EN: decreases step down 1 per cycle.
module speed_limit_arbiter #(
   parameter logic [7:0]  DEFAULT_LIMIT = 8'd30,
   parameter logic [7:0]  MAX_LIMIT     = 8'd200,
   parameter logic [7:0]  HOLD_CYCLES   = 8'd16,
   parameter logic [15:0] STALE_CYCLES  = 16'd255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       drv_req,
   input  logic [7:0] drv_limit,
   input  logic       sign_req,
   input  logic [7:0] sign_limit,
   input  logic       map_req,
   input  logic [7:0] map_limit,
   output logic       drv_ack,
   output logic       sign_ack,
   output logic       map_ack,
   output logic [7:0] speed_limit,
   output logic [1:0] limit_src,
   output logic       limit_valid
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_MAP  = 2'd1;
   localparam logic [1:0] SRC_SIGN = 2'd2;
   localparam logic [1:0] SRC_DRV  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  r_src;
   logic [7:0]  r_speed;
   logic [7:0]  r_hold;
   logic [15:0] r_stale;
   logic        r_valid;
   logic        r_drv_ack;
   logic        r_sign_ack;
   logic        r_map_ack;

   logic [1:0]  w_min_prio;
   logic        w_elig_drv;
   logic        w_elig_sign;
   logic        w_elig_map;
   logic        w_take_drv;
   logic        w_take_sign;
   logic        w_take_map;
   logic        w_acc;
   logic [1:0]  w_acc_src;
   logic [7:0]  w_acc_lim;
   logic [7:0]  w_acc_val;
   logic [7:0]  w_cur_tgt;
   logic [1:0]  w_state_nxt;
   logic [1:0]  w_src_nxt;
   logic [7:0]  w_tgt_nxt;
   logic [7:0]  w_hold_nxt;
   logic [15:0] w_stale_nxt;

   // Only HOLD restricts eligibility to the owner's priority or higher.
   assign w_min_prio  = (r_state == ST_HOLD) ? r_src : SRC_MAP;
   assign w_elig_drv  = drv_req  && (drv_limit  != 8'd0) && (SRC_DRV  >= w_min_prio);
   assign w_elig_sign = sign_req && (sign_limit != 8'd0) && (SRC_SIGN >= w_min_prio);
   assign w_elig_map  = map_req  && (map_limit  != 8'd0) && (SRC_MAP  >= w_min_prio);

   assign w_take_drv  = w_elig_drv;
   assign w_take_sign = w_elig_sign && !w_elig_drv;
   assign w_take_map  = w_elig_map && !w_elig_sign && !w_elig_drv;
   assign w_acc       = w_take_drv || w_take_sign || w_take_map;

   always_comb begin
      w_acc_src = SRC_NONE;
      w_acc_lim = 8'd0;
      if (w_take_drv) begin
         w_acc_src = SRC_DRV;
         w_acc_lim = drv_limit;
      end else if (w_take_sign) begin
         w_acc_src = SRC_SIGN;
         w_acc_lim = sign_limit;
      end else if (w_take_map) begin
         w_acc_src = SRC_MAP;
         w_acc_lim = map_limit;
      end
   end

   assign w_acc_val = (w_acc_lim > MAX_LIMIT) ? MAX_LIMIT : w_acc_lim;

   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_tgt_nxt   = w_cur_tgt;
      w_hold_nxt  = r_hold;
      w_stale_nxt = r_stale;
      if (w_acc) begin
         w_src_nxt   = w_acc_src;
         w_tgt_nxt   = w_acc_val;
         w_stale_nxt = 16'd0;
         if (w_acc_src != r_src) begin
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = HOLD_CYCLES - 8'd1;
         end else if (r_hold != 8'd0) begin
            w_hold_nxt = r_hold - 8'd1;
         end
      end else if (r_state != ST_IDLE) begin
         if (r_stale >= STALE_CYCLES - 16'd1) begin
            w_state_nxt = ST_IDLE;
            w_src_nxt   = SRC_NONE;
            w_tgt_nxt   = DEFAULT_LIMIT;
            w_hold_nxt  = 8'd0;
            w_stale_nxt = 16'd0;
         end else begin
            w_stale_nxt = r_stale + 16'd1;
            if (r_state == ST_HOLD) begin
               if (r_hold == 8'd0) w_state_nxt = ST_TRACK;
               else                w_hold_nxt  = r_hold - 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_src      <= SRC_NONE;
         r_hold     <= 8'd0;
         r_stale    <= 16'd0;
         r_valid    <= 1'b0;
         r_drv_ack  <= 1'b0;
         r_sign_ack <= 1'b0;
         r_map_ack  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_src      <= w_src_nxt;
         r_hold     <= w_hold_nxt;
         r_stale    <= w_stale_nxt;
         r_valid    <= (w_state_nxt != ST_IDLE);
         r_drv_ack  <= w_take_drv;
         r_sign_ack <= w_take_sign;
         r_map_ack  <= w_take_map;
      end
   end

`ifdef SPEED_LIMIT_RAMP_EN
   logic [7:0] r_tgt;

   assign w_cur_tgt = r_tgt;

   // Rises load at once; falls walk the output down one step per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tgt   <= DEFAULT_LIMIT;
         r_speed <= DEFAULT_LIMIT;
      end else begin
         r_tgt <= w_tgt_nxt;
         if (w_tgt_nxt >= r_speed) r_speed <= w_tgt_nxt;
         else                      r_speed <= r_speed - 8'd1;
      end
   end
`else
   assign w_cur_tgt = r_speed;

   always_ff @(posedge clk) begin
      if (rst) r_speed <= DEFAULT_LIMIT;
      else     r_speed <= w_tgt_nxt;
   end
`endif

   assign drv_ack     = r_drv_ack;
   assign sign_ack    = r_sign_ack;
   assign map_ack     = r_map_ack;
   assign speed_limit = r_speed;
   assign limit_src   = r_src;
   assign limit_valid = r_valid;

endmodule

// File: tb/tb_speed_limit_arbiter.sv
// Scoreboarded bench for speed_limit_arbiter: directed scenarios plus randomized requesters against a timestamp-based model.
module tb_speed_limit_arbiter;

   localparam int HOLD  = 16;
   localparam int STALE = 255;
   localparam int DEFL  = 30;
   localparam int MAXL  = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drv_req = 1'b0, sign_req = 1'b0, map_req = 1'b0;
   logic [7:0] drv_limit = 8'd0, sign_limit = 8'd0, map_limit = 8'd0;
   logic       drv_ack, sign_ack, map_ack, limit_valid;
   logic [7:0] speed_limit;
   logic [1:0] limit_src;

   speed_limit_arbiter dut (
      .clk(clk), .rst(rst),
      .drv_req(drv_req), .drv_limit(drv_limit),
      .sign_req(sign_req), .sign_limit(sign_limit),
      .map_req(map_req), .map_limit(map_limit),
      .drv_ack(drv_ack), .sign_ack(sign_ack), .map_ack(map_ack),
      .speed_limit(speed_limit), .limit_src(limit_src), .limit_valid(limit_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] spd;
      logic [1:0] src;
      logic       vld;
      logic [2:0] ack;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Model: owner, its target, and edge timestamps of last owner change / last acceptance.
   int       m_owner = 0, m_tgt = DEFL, m_disp = DEFL;
   longint   m_n = 0, m_tchg = 0, m_tacc = 0;
   bit       m_hext = 0;
   bit [3:1] m_ack = 3'b000;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit dq, input int dl, input bit sq, input int sl,
                      input bit mq, input int ml);
      int   lim[4];
      bit   rq[4];
      int   win, minp;
      bit   in_hold;
      obs_t e;
      rst = r;
      drv_req = dq;  drv_limit = dl[7:0];
      sign_req = sq; sign_limit = sl[7:0];
      map_req = mq;  map_limit = ml[7:0];
      lim[3] = dl & 255; lim[2] = sl & 255; lim[1] = ml & 255; lim[0] = 0;
      rq[3] = dq; rq[2] = sq; rq[1] = mq; rq[0] = 0;
      m_n++;
      m_ack = 3'b000;
      if (r) begin
         m_owner = 0; m_tgt = DEFL; m_disp = DEFL; m_hext = 0;
      end else begin
         in_hold = (m_owner != 0) && ((m_n - m_tchg) <= HOLD || m_hext);
         minp = in_hold ? m_owner : 1;
         win = 0;
         for (int p = 3; p >= 1; p--)
            if (win == 0 && rq[p] && lim[p] != 0 && p >= minp) win = p;
         m_hext = 0;
         if (win != 0) begin
            m_ack[win] = 1'b1;
            if (win != m_owner) m_tchg = m_n;
            else                m_hext = in_hold;
            m_owner = win;
            m_tgt   = (lim[win] > MAXL) ? MAXL : lim[win];
            m_tacc  = m_n;
         end else if (m_owner != 0 && (m_n - m_tacc) >= STALE) begin
            m_owner = 0;
            m_tgt   = DEFL;
         end
`ifdef SPEED_LIMIT_RAMP_EN
         if (m_tgt >= m_disp) m_disp = m_tgt;
         else                 m_disp = m_disp - 1;
`else
         m_disp = m_tgt;
`endif
      end
      e.spd = m_disp[7:0];
      e.src = m_owner[1:0];
      e.vld = (m_owner != 0);
      e.ack = m_ack;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every edge the DUT presents a full output word; compare with the oldest prediction.
   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {speed_limit, limit_src, limit_valid, drv_ack, sign_ack, map_ack};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL obs t=%0t: got spd=%0d src=%0d vld=%0b ack=%b, expected spd=%0d src=%0d vld=%0b ack=%b",
                        $time, g.spd, g.src, g.vld, g.ack, e.spd, e.src, e.vld, e.ack);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   bit busy[4];
   int alim[4];
   int atim[4];
   int rates[7] = '{10, 12, 0, 15, 3, 0, 10};

   initial begin
      int k;
      bit got;
      @(posedge clk);
      #2;
      // Reset state.
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
      chk("reset_spd", speed_limit, 30);
      chk("reset_src", limit_src, 0);
      chk("reset_vld", limit_valid, 0);

      // Single map request from IDLE.
      cyc(0, 0, 0, 0, 0, 1, 60);
      chk("map_ack_pulse", map_ack, 1);
      chk("map_spd", speed_limit, 60);
      chk("map_src", limit_src, 1);
      chk("map_vld", limit_valid, 1);
      idle(1);
      chk("map_ack_drop", map_ack, 0);

      // Reset mid-operation while sign owns 50.
      cyc(0, 0, 0, 1, 50, 0, 0);
      idle(3);
      repeat (5) cyc(1, 0, 0, 0, 0, 0, 0);
      chk("midrst_spd", speed_limit, 30);
      chk("midrst_src", limit_src, 0);
      chk("midrst_vld", limit_valid, 0);
      chk("midrst_acks", {drv_ack, sign_ack, map_ack}, 0);

      // Simultaneous sign/map; map held through the hold window.
      cyc(0, 0, 0, 1, 50, 1, 80);
      chk("sim_sign_ack", sign_ack, 1);
      chk("sim_map_ack", map_ack, 0);
      chk("sim_spd", speed_limit, 50);
      chk("sim_src", limit_src, 2);
      k = 0; got = 0;
      while (!got && k < 40) begin
         cyc(0, 0, 0, 0, 0, 1, 80);
         k++;
         if (map_ack) got = 1;
      end
      chk("map_wait_cycles", k, 17);
      chk("track_map_spd", speed_limit, 80);
      chk("track_map_src", limit_src, 1);

      // Preemption in HOLD, clamping, invalid zero limit, lower priority ignored.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 60);
      idle(2);
      cyc(0, 0, 0, 1, 40, 0, 0);
      chk("preempt_sign_ack", sign_ack, 1);
      chk("preempt_src", limit_src, 2);
`ifdef SPEED_LIMIT_RAMP_EN
      chk("preempt_spd", speed_limit, 59);
`else
      chk("preempt_spd", speed_limit, 40);
`endif
      cyc(0, 1, 250, 0, 0, 0, 0);
      chk("clamp_drv_ack", drv_ack, 1);
      chk("clamp_spd", speed_limit, 200);
      chk("clamp_src", limit_src, 3);
      cyc(0, 0, 0, 1, 70, 0, 0);
      chk("lowprio_no_ack", sign_ack, 0);
      chk("lowprio_src", limit_src, 3);
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
      chk("zero_no_ack", drv_ack, 0);
      chk("zero_spd", speed_limit, 200);

      // Stale expiry.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 60);
      k = 0;
      while (limit_valid && k < 300) begin
         idle(1);
         k++;
      end
      chk("stale_cycles", k, 255);
      chk("stale_src", limit_src, 0);
`ifdef SPEED_LIMIT_RAMP_EN
      chk("stale_spd", speed_limit, 59);
`else
      chk("stale_spd", speed_limit, 30);
`endif

      // Refresh on the very cycle of expiry wins and clears the timer.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 45, 0, 0);
      idle(254);
      cyc(0, 0, 0, 1, 45, 0, 0);
      chk("expiry_refresh_ack", sign_ack, 1);
      chk("expiry_refresh_vld", limit_valid, 1);
      idle(254);
      chk("timer_cleared_vld", limit_valid, 1);
      idle(1);
      chk("timer_expired_vld", limit_valid, 0);

      // Decrease then increase by the driver.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 60, 0, 0, 0, 0);
      idle(1);
      cyc(0, 1, 55, 0, 0, 0, 0);
`ifdef SPEED_LIMIT_RAMP_EN
      chk("ramp_step_59", speed_limit, 59);
      for (int v = 58; v >= 55; v--) begin
         idle(1);
         chk("ramp_step", speed_limit, v);
      end
`else
      chk("dec_load_55", speed_limit, 55);
`endif
      idle(20);
      cyc(0, 1, 90, 0, 0, 0, 0);
      chk("inc_load_90", speed_limit, 90);
      chk("inc_src", limit_src, 3);

      // Randomized requesters that hold req until acked or they give up.
      for (int p = 0; p < 4; p++) begin busy[p] = 0; alim[p] = 0; atim[p] = 0; end
      for (int seg = 0; seg < 7; seg++) begin
         for (int c = 0; c < 500; c++) begin
            bit r;
            for (int p = 1; p <= 3; p++) begin
               if (busy[p] && (m_ack[p] || atim[p] == 0)) busy[p] = 0;
               else if (busy[p]) atim[p]--;
               else if ($urandom_range(0, 99) < rates[seg]) begin
                  busy[p] = 1;
                  atim[p] = $urandom_range(3, 40);
                  case ($urandom_range(0, 9))
                     0:       alim[p] = 0;
                     1:       alim[p] = $urandom_range(201, 255);
                     default: alim[p] = $urandom_range(1, 200);
                  endcase
               end
            end
            r = ($urandom_range(0, 999) == 0);
            cyc(r, busy[3], alim[3], busy[2], alim[2], busy[1], alim[1]);
         end
      end

      idle(2);
      k = 0;
      while (exp_q.size() > 0 && k < 10) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
